vga_timing_controller_runtime: RTL and testbench
================================================

# vga_timing_controller_runtime

Runtime-switchable VGA timing generator: produces pixel coordinates, sync pulses, active-video qualifier and frame/line markers for one of four built-in video modes, with the mode changeable while running. Mode changes are requested via a request/acknowledge handshake and applied only on a frame boundary, so the display never sees a torn frame. Sits directly after the pixel clock source and drives the pixel pipeline, the frame buffer reader and the VGA output pins.

## Interface
Parameters:
- COORD_WIDTH, 12, width of x/y counters and coordinate/size outputs (≥ 12)
- DEFAULT_MODE, 0, mode index loaded at reset (0..3)

Ports:
- clk_pixel  in  1  pixel clock; frequency must match the active mode (25.175 / 40 / 65 / 148.5 MHz)
- reset  in  1  asynchronous, active-high reset
- mode_sel  in  2  requested mode index, sampled when mode_req is high
- mode_req  in  1  mode change request (level sampled each cycle)
- mode_ack  out  1  one-cycle pulse: new mode has taken effect
- mode_cur  out  2  mode index currently in effect
- vga_hsync  out  1  horizontal sync, mode polarity applied
- vga_vsync  out  1  vertical sync, mode polarity applied
- vga_x  out  COORD_WIDTH  horizontal position, 0..H_TOTAL-1
- vga_y  out  COORD_WIDTH  vertical position, 0..V_TOTAL-1
- video_active  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- line_start  out  1  pulse when vga_x = 0
- frame_start  out  1  pulse when vga_x = 0 and vga_y = 0
- screen_width  out  COORD_WIDTH  H_ACTIVE of mode_cur
- screen_height  out  COORD_WIDTH  V_ACTIVE of mode_cur

## Operation
- Mode table (H active/FP/sync/BP, V active/FP/sync/BP, polarity):
  - 0: 640/16/96/48, 480/10/2/33, negative (totals 800×525)
  - 1: 800/40/128/88, 600/1/4/23, positive (1056×628)
  - 2: 1024/24/136/160, 768/3/6/29, negative (1344×806)
  - 3: 1920/88/44/148, 1080/4/5/36, positive (2200×1125)
- Counter stage: cx increments each cycle; at H_TOTAL-1 wraps to 0 and cy increments; cy wraps to 0 after V_TOTAL-1 when cx wraps.
- Sync active when H_ACTIVE+HFP ≤ cx < H_ACTIVE+HFP+HSYNC (likewise vertical, on cy only). Pin level = active ? POL : ~POL (positive: high during pulse).
- Output stage registers cx, cy, active, syncs, markers — all outputs are flops.
- Mode handshake:
  - mode_req high: latch mode_sel into pend_mode, set pending. Further requests while pending overwrite pend_mode (last wins).
  - At counter position (H_TOTAL-1, V_TOTAL-1) with pending already set before that cycle: next cycle counters = (0,0), mode_cur = pend_mode, pending cleared, internal ack set.
  - Request in the same cycle as frame end: captured, applied at the following frame end.
  - Request for the mode already in effect: still waits for frame end and is acknowledged.
- screen_width/screen_height/mode_cur change in the same cycle as mode_ack.
- Timing constants come from mode_cur only; never mixed mid-frame.

## Timing
- Reset (async, immediate): cx=cy=0, mode_cur=DEFAULT_MODE, pending=0; outputs vga_x=vga_y=0, video_active=0, line_start=frame_start=0, mode_ack=0, syncs at inactive level of DEFAULT_MODE, screen size of DEFAULT_MODE.
- First cycle after reset release: counters advance; outputs show (0,0), video_active=1, frame_start=1, line_start=1 one cycle after release (1-cycle output latency).
- All outputs lag the counter by exactly one cycle, mutually aligned.
- mode_ack pulses for one cycle, coincident with frame_start of the first frame in the new mode.
- Latency request→ack: from 2 cycles to one frame + 2 cycles.
- Reset mid-frame or with pending request: pending dropped, mode reverts to DEFAULT_MODE, no ack.

## Test plan
- Reset with DEFAULT_MODE=0, run 2 frames -> frame_start every 420000 cycles; hsync low for 96 cycles starting at x=656; vsync low for y=490..491; video_active count per frame = 307200.
- Mode 3 steady-state -> line length 2200, hsync high at x=2008..2051, vsync high at y=1084..1088, screen_width=1920, screen_height=1080.
- mode_req pulse selecting 1 at mid-frame of mode 0 -> no change until after (799,524); next cycle output (0,0), mode_ack=1, mode_cur=1, screen_width=800; next line 1056 cycles.
- Two requests (2 then 3) in the same frame -> single ack, mode_cur=3.
- Request asserted exactly at cycle (H_TOTAL-1, V_TOTAL-1) -> not applied this frame; applied and acked at next frame boundary.
- Assert reset mid-frame with request pending -> all outputs to reset values immediately; no mode_ack; mode_cur=DEFAULT_MODE after release.

Source files
------------

// File: rtl/vga_timing_controller_runtime_if.sv
// rtl/vga_timing_controller_runtime_if.sv - mode change request/acknowledge bundle
interface vga_timing_controller_runtime_if;
    logic [1:0] mode_sel;
    logic       mode_req;
    logic       mode_ack;
    logic [1:0] mode_cur;

    modport master (
        output mode_sel,
        output mode_req,
        input  mode_ack,
        input  mode_cur
    );

    modport slave (
        input  mode_sel,
        input  mode_req,
        output mode_ack,
        output mode_cur
    );
endinterface

// File: rtl/vga_timing_controller_runtime.sv
// rtl/vga_timing_controller_runtime.sv - VGA timing generator with four modes switched on frame boundaries
module vga_timing_controller_runtime #(
    parameter int         COORD_WIDTH  = 12,
    parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
    input  logic                           clk_pixel,
    input  logic                           reset,
    vga_timing_controller_runtime_if.slave mode_if,
    output logic                           vga_hsync,
    output logic                           vga_vsync,
    output logic [COORD_WIDTH-1:0]         vga_x,
    output logic [COORD_WIDTH-1:0]         vga_y,
    output logic                           video_active,
    output logic                           line_start,
    output logic                           frame_start,
    output logic [COORD_WIDTH-1:0]         screen_width,
    output logic [COORD_WIDTH-1:0]         screen_height
);

    typedef logic [COORD_WIDTH-1:0] coord_t;

    // Sync windows are stored as [start, end) so the comparisons need no adders.
    typedef struct packed {
        coord_t h_active;
        coord_t h_sync_start;
        coord_t h_sync_end;
        coord_t h_total;
        coord_t v_active;
        coord_t v_sync_start;
        coord_t v_sync_end;
        coord_t v_total;
        logic   pol;
    } timing_t;

    function automatic timing_t timing_of(input logic [1:0] m);
        timing_t t;
        case (m)
            // 640x480: 640/16/96/48, 480/10/2/33, negative sync
            2'd0: t = '{coord_t'(640),  coord_t'(656),  coord_t'(752),  coord_t'(800),
                        coord_t'(480),  coord_t'(490),  coord_t'(492),  coord_t'(525),  1'b0};
            // 800x600: 800/40/128/88, 600/1/4/23, positive sync
            2'd1: t = '{coord_t'(800),  coord_t'(840),  coord_t'(968),  coord_t'(1056),
                        coord_t'(600),  coord_t'(601),  coord_t'(605),  coord_t'(628),  1'b1};
            // 1024x768: 1024/24/136/160, 768/3/6/29, negative sync
            2'd2: t = '{coord_t'(1024), coord_t'(1048), coord_t'(1184), coord_t'(1344),
                        coord_t'(768),  coord_t'(771),  coord_t'(777),  coord_t'(806),  1'b0};
            // 1920x1080: 1920/88/44/148, 1080/4/5/36, positive sync
            default: t = '{coord_t'(1920), coord_t'(2008), coord_t'(2052), coord_t'(2200),
                           coord_t'(1080), coord_t'(1084), coord_t'(1089), coord_t'(1125), 1'b1};
        endcase
        return t;
    endfunction

    localparam timing_t RESET_TM = timing_of(DEFAULT_MODE);
    localparam coord_t  ONE      = coord_t'(1);

    // Counter stage state
    coord_t     cx_q, cx_d;
    coord_t     cy_q, cy_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] pend_mode_q, pend_mode_d;
    logic       pend_q, pend_d;
    logic       ack_q, ack_d;

    timing_t    tm;
    logic       h_last;
    logic       v_last;
    logic       apply;
    logic       hsync_on;
    logic       vsync_on;
    logic       active_d;

    // All geometry comes from the mode in effect, which only changes at the frame wrap.
    assign tm     = timing_of(mode_q);
    assign h_last = (cx_q == tm.h_total - ONE);
    assign v_last = (cy_q == tm.v_total - ONE);

    // A pending request (set before this cycle) is applied at the last pixel of the frame.
    assign apply  = h_last && v_last && pend_q;

    assign cx_d = h_last ? '0 : cx_q + ONE;
    assign cy_d = h_last ? (v_last ? '0 : cy_q + ONE) : cy_q;

    // A request arriving on the apply cycle re-arms pending for the next frame; last request wins.
    assign pend_d      = mode_if.mode_req | (pend_q & ~apply);
    assign pend_mode_d = mode_if.mode_req ? mode_if.mode_sel : pend_mode_q;
    assign mode_d      = apply ? pend_mode_q : mode_q;
    assign ack_d       = apply;

    assign hsync_on = (cx_q >= tm.h_sync_start) && (cx_q < tm.h_sync_end);
    assign vsync_on = (cy_q >= tm.v_sync_start) && (cy_q < tm.v_sync_end);
    assign active_d = (cx_q < tm.h_active) && (cy_q < tm.v_active);

    // Counter, mode and handshake state
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cx_q        <= '0;
            cy_q        <= '0;
            mode_q      <= DEFAULT_MODE;
            pend_mode_q <= DEFAULT_MODE;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            ack_q       <= ack_d;
        end
    end

    // Output stage: every output is one cycle behind the counters, so ack, mode and size line up with (0,0)
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            vga_x            <= '0;
            vga_y            <= '0;
            video_active     <= 1'b0;
            line_start       <= 1'b0;
            frame_start      <= 1'b0;
            vga_hsync        <= ~RESET_TM.pol;
            vga_vsync        <= ~RESET_TM.pol;
            screen_width     <= RESET_TM.h_active;
            screen_height    <= RESET_TM.v_active;
            mode_if.mode_ack <= 1'b0;
            mode_if.mode_cur <= DEFAULT_MODE;
        end else begin
            vga_x            <= cx_q;
            vga_y            <= cy_q;
            video_active     <= active_d;
            line_start       <= (cx_q == '0);
            frame_start      <= (cx_q == '0) && (cy_q == '0);
            vga_hsync        <= hsync_on ? tm.pol : ~tm.pol;
            vga_vsync        <= vsync_on ? tm.pol : ~tm.pol;
            screen_width     <= tm.h_active;
            screen_height    <= tm.v_active;
            mode_if.mode_ack <= ack_q;
            mode_if.mode_cur <= mode_q;
        end
    end

endmodule

// File: tb/tb_vga_timing_controller_runtime.sv
// tb/tb_vga_timing_controller_runtime.sv - directed bench for the runtime VGA timing generator
module tb_vga_timing_controller_runtime;

    logic        clk;
    logic        reset;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [11:0] vga_x;
    logic [11:0] vga_y;
    logic        video_active;
    logic        line_start;
    logic        frame_start;
    logic [11:0] screen_width;
    logic [11:0] screen_height;
    logic [11:0] jx;
    logic [11:0] jy;

    int tests;
    int fails;

    vga_timing_controller_runtime_if mif ();

    vga_timing_controller_runtime #(
        .COORD_WIDTH  (12),
        .DEFAULT_MODE (2'd0)
    ) dut (
        .clk_pixel     (clk),
        .reset         (reset),
        .mode_if       (mif),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .video_active  (video_active),
        .line_start    (line_start),
        .frame_start   (frame_start),
        .screen_width  (screen_width),
        .screen_height (screen_height)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one clock; outputs are then sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // place the counters at (x,y) on the next edge so frame ends are reachable in a short run
    task automatic jump_to(input int x, input int y);
        jx = 12'(x);
        jy = 12'(y);
        force dut.cx_d = jx;
        force dut.cy_d = jy;
        @(posedge clk);
        #1;
        release dut.cx_d;
        release dut.cy_d;
        @(negedge clk);
    endtask

    task automatic request(input logic [1:0] m);
        mif.mode_sel = m;
        mif.mode_req = 1'b1;
        step();
        mif.mode_req = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (vga_x !== 12'd0) begin fails++; $display("FAIL rst_x got=%0d exp=0", vga_x); end
        tests++; if (video_active !== 1'b0) begin fails++; $display("FAIL rst_active got=%b exp=0", video_active); end
        tests++; if ({line_start, frame_start, mif.mode_ack} !== 3'b000) begin fails++; $display("FAIL rst_pulses got=%b exp=000", {line_start, frame_start, mif.mode_ack}); end
        tests++; if ({vga_hsync, vga_vsync} !== 2'b11) begin fails++; $display("FAIL rst_sync got=%b exp=11", {vga_hsync, vga_vsync}); end
        tests++; if (screen_width !== 12'd640 || screen_height !== 12'd480) begin fails++; $display("FAIL rst_size got=%0dx%0d exp=640x480", screen_width, screen_height); end
        tests++; if (mif.mode_cur !== 2'd0) begin fails++; $display("FAIL rst_mode got=%0d exp=0", mif.mode_cur); end
        reset = 1'b0;
        step();
        tests++; if ({vga_x, vga_y} !== 24'd0) begin fails++; $display("FAIL first_xy got=%0d,%0d exp=0,0", vga_x, vga_y); end
        tests++; if ({video_active, line_start, frame_start} !== 3'b111) begin fails++; $display("FAIL first_flags got=%b exp=111", {video_active, line_start, frame_start}); end
    endtask

    task automatic test_mode0_line();
        int hs_low;
        int hs_first;
        int act;
        hs_low = 0; hs_first = -1; act = 0;
        for (int i = 0; i < 800; i++) begin
            if (vga_hsync == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(vga_x);
            end
            if (video_active) act++;
            step();
        end
        tests++; if (hs_low != 96) begin fails++; $display("FAIL m0_hs_len got=%0d exp=96", hs_low); end
        tests++; if (hs_first != 656) begin fails++; $display("FAIL m0_hs_start got=%0d exp=656", hs_first); end
        tests++; if (act != 640) begin fails++; $display("FAIL m0_line_active got=%0d exp=640", act); end
        tests++; if (vga_x !== 12'd0 || vga_y !== 12'd1 || line_start !== 1'b1) begin fails++; $display("FAIL m0_wrap got=%0d,%0d ls=%b exp=0,1 ls=1", vga_x, vga_y, line_start); end
    endtask

    task automatic test_mode0_vertical();
        int vs_low;
        int vs_min;
        int vs_max;
        int act;
        vs_low = 0; vs_min = 4095; vs_max = -1; act = 0;
        jump_to(0, 489);
        step();
        for (int i = 0; i < 3200; i++) begin
            if (vga_vsync == 1'b0) begin
                vs_low++;
                if (int'(vga_y) < vs_min) vs_min = int'(vga_y);
                if (int'(vga_y) > vs_max) vs_max = int'(vga_y);
            end
            step();
        end
        tests++; if (vs_low != 1600) begin fails++; $display("FAIL m0_vs_len got=%0d exp=1600", vs_low); end
        tests++; if (vs_min != 490 || vs_max != 491) begin fails++; $display("FAIL m0_vs_rows got=%0d..%0d exp=490..491", vs_min, vs_max); end
        jump_to(0, 479);
        step();
        for (int i = 0; i < 1600; i++) begin
            if (video_active) act++;
            step();
        end
        tests++; if (act != 640) begin fails++; $display("FAIL m0_last_rows_active got=%0d exp=640", act); end
    endtask

    task automatic test_frame_wrap();
        jump_to(798, 524);
        step();
        step();
        tests++; if (vga_x !== 12'd799 || vga_y !== 12'd524 || frame_start !== 1'b0) begin fails++; $display("FAIL fw_last got=%0d,%0d fs=%b exp=799,524 fs=0", vga_x, vga_y, frame_start); end
        step();
        tests++; if ({vga_x, vga_y} !== 24'd0 || frame_start !== 1'b1 || line_start !== 1'b1) begin fails++; $display("FAIL fw_origin got=%0d,%0d fs=%b ls=%b exp=0,0 fs=1 ls=1", vga_x, vga_y, frame_start, line_start); end
        tests++; if (mif.mode_ack !== 1'b0) begin fails++; $display("FAIL fw_no_ack got=%b exp=0", mif.mode_ack); end
    endtask

    task automatic test_mode_change();
        int hs_high;
        int hs_first;
        int acks;
        hs_high = 0; hs_first = -1; acks = 0;
        repeat (100) step();
        request(2'd1);
        repeat (50) step();
        tests++; if (mif.mode_cur !== 2'd0 || screen_width !== 12'd640) begin fails++; $display("FAIL mc_early got mode=%0d w=%0d exp mode=0 w=640", mif.mode_cur, screen_width); end
        jump_to(798, 524);
        step();
        step();
        tests++; if (mif.mode_ack !== 1'b0 || mif.mode_cur !== 2'd0) begin fails++; $display("FAIL mc_before got ack=%b mode=%0d exp ack=0 mode=0", mif.mode_ack, mif.mode_cur); end
        step();
        tests++; if ({vga_x, vga_y} !== 24'd0 || mif.mode_ack !== 1'b1 || frame_start !== 1'b1) begin fails++; $display("FAIL mc_ack got=%0d,%0d ack=%b fs=%b exp=0,0 ack=1 fs=1", vga_x, vga_y, mif.mode_ack, frame_start); end
        tests++; if (mif.mode_cur !== 2'd1 || screen_width !== 12'd800 || screen_height !== 12'd600) begin fails++; $display("FAIL mc_mode got mode=%0d %0dx%0d exp mode=1 800x600", mif.mode_cur, screen_width, screen_height); end
        for (int i = 0; i < 1056; i++) begin
            if (mif.mode_ack) acks++;
            if (vga_hsync == 1'b1) begin
                hs_high++;
                if (hs_first < 0) hs_first = int'(vga_x);
            end
            step();
        end
        tests++; if (acks != 1) begin fails++; $display("FAIL mc_ack_width got=%0d exp=1", acks); end
        tests++; if (hs_high != 128 || hs_first != 840) begin fails++; $display("FAIL m1_hsync got len=%0d start=%0d exp len=128 start=840", hs_high, hs_first); end
        tests++; if (vga_x !== 12'd0 || vga_y !== 12'd1 || line_start !== 1'b1) begin fails++; $display("FAIL m1_line got=%0d,%0d ls=%b exp=0,1 ls=1", vga_x, vga_y, line_start); end
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        request(2'd2);
        repeat (10) step();
        request(2'd3);
        jump_to(1053, 627);
        for (int i = 0; i < 8; i++) begin
            step();
            if (mif.mode_ack) acks++;
        end
        tests++; if (acks != 1) begin fails++; $display("FAIL b2b_acks got=%0d exp=1", acks); end
        tests++; if (mif.mode_cur !== 2'd3 || screen_width !== 12'd1920 || screen_height !== 12'd1080) begin fails++; $display("FAIL b2b_mode got mode=%0d %0dx%0d exp mode=3 1920x1080", mif.mode_cur, screen_width, screen_height); end
    endtask

    task automatic test_mode3();
        int hs_high;
        int hs_first;
        int vs_high;
        int vs_min;
        int vs_max;
        hs_high = 0; hs_first = -1; vs_high = 0; vs_min = 4095; vs_max = -1;
        jump_to(0, 5);
        step();
        for (int i = 0; i < 2200; i++) begin
            if (vga_hsync == 1'b1) begin
                hs_high++;
                if (hs_first < 0) hs_first = int'(vga_x);
            end
            step();
        end
        tests++; if (hs_high != 44 || hs_first != 2008) begin fails++; $display("FAIL m3_hsync got len=%0d start=%0d exp len=44 start=2008", hs_high, hs_first); end
        tests++; if (vga_x !== 12'd0 || vga_y !== 12'd6) begin fails++; $display("FAIL m3_line got=%0d,%0d exp=0,6", vga_x, vga_y); end
        jump_to(0, 1083);
        step();
        for (int i = 0; i < 15400; i++) begin
            if (vga_vsync == 1'b1) begin
                vs_high++;
                if (int'(vga_y) < vs_min) vs_min = int'(vga_y);
                if (int'(vga_y) > vs_max) vs_max = int'(vga_y);
            end
            step();
        end
        tests++; if (vs_high != 11000) begin fails++; $display("FAIL m3_vs_len got=%0d exp=11000", vs_high); end
        tests++; if (vs_min != 1084 || vs_max != 1088) begin fails++; $display("FAIL m3_vs_rows got=%0d..%0d exp=1084..1088", vs_min, vs_max); end
    endtask

    task automatic test_req_at_frame_end();
        int acks;
        acks = 0;
        jump_to(2197, 1124);
        step();
        step();
        mif.mode_sel = 2'd0;
        mif.mode_req = 1'b1;
        step();
        mif.mode_req = 1'b0;
        step();
        tests++; if ({vga_x, vga_y} !== 24'd0 || mif.mode_ack !== 1'b0 || mif.mode_cur !== 2'd3) begin fails++; $display("FAIL fe_deferred got=%0d,%0d ack=%b mode=%0d exp=0,0 ack=0 mode=3", vga_x, vga_y, mif.mode_ack, mif.mode_cur); end
        jump_to(2197, 1124);
        for (int i = 0; i < 4; i++) begin
            step();
            if (mif.mode_ack) acks++;
        end
        tests++; if (acks != 1 || mif.mode_ack !== 1'b1 || frame_start !== 1'b1) begin fails++; $display("FAIL fe_applied got acks=%0d ack=%b fs=%b exp acks=1 ack=1 fs=1", acks, mif.mode_ack, frame_start); end
        tests++; if (mif.mode_cur !== 2'd0 || screen_width !== 12'd640) begin fails++; $display("FAIL fe_mode got mode=%0d w=%0d exp mode=0 w=640", mif.mode_cur, screen_width); end
    endtask

    task automatic test_same_mode();
        request(2'd0);
        jump_to(798, 524);
        step();
        step();
        step();
        tests++; if (mif.mode_ack !== 1'b1 || mif.mode_cur !== 2'd0) begin fails++; $display("FAIL same_mode got ack=%b mode=%0d exp ack=1 mode=0", mif.mode_ack, mif.mode_cur); end
    endtask

    task automatic test_reset_pending();
        int acks;
        acks = 0;
        request(2'd1);
        jump_to(798, 524);
        step();
        step();
        step();
        tests++; if (mif.mode_cur !== 2'd1) begin fails++; $display("FAIL rp_setup got mode=%0d exp=1", mif.mode_cur); end
        request(2'd2);
        repeat (20) step();
        #2;
        reset = 1'b1;
        #1;
        tests++; if ({vga_x, vga_y} !== 24'd0 || video_active !== 1'b0) begin fails++; $display("FAIL rp_async got=%0d,%0d act=%b exp=0,0 act=0", vga_x, vga_y, video_active); end
        tests++; if (mif.mode_cur !== 2'd0 || screen_width !== 12'd640 || {vga_hsync, vga_vsync} !== 2'b11) begin fails++; $display("FAIL rp_mode got mode=%0d w=%0d sync=%b exp mode=0 w=640 sync=11", mif.mode_cur, screen_width, {vga_hsync, vga_vsync}); end
        @(negedge clk);
        reset = 1'b0;
        step();
        tests++; if (frame_start !== 1'b1 || vga_x !== 12'd0) begin fails++; $display("FAIL rp_restart got fs=%b x=%0d exp fs=1 x=0", frame_start, vga_x); end
        jump_to(798, 524);
        for (int i = 0; i < 4; i++) begin
            step();
            if (mif.mode_ack) acks++;
        end
        tests++; if (acks != 0 || mif.mode_cur !== 2'd0) begin fails++; $display("FAIL rp_dropped got acks=%0d mode=%0d exp acks=0 mode=0", acks, mif.mode_cur); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        jx = '0;
        jy = '0;
        reset = 1'b1;
        mif.mode_sel = 2'd0;
        mif.mode_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_mode0_line();
        test_mode0_vertical();
        test_frame_wrap();
        test_mode_change();
        test_back_to_back();
        test_mode3();
        test_req_at_frame_end();
        test_same_mode();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
